// File: rtl/axi_slave_wr_ctrl.sv
// AXI4 slave write-channel controller: one burst at a time (AW -> W beats -> B),
// generating FIXED/INCR/WRAP beat addresses for a byte-strobed synchronous memory port.
module axi_slave_wr_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic [1:0]              dbg_state
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int MAX_SIZE = $clog2(STRB_W);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // both VALID and READY are high; READY/VALID outputs are registered.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] cur_addr, wrap_lo, wrap_hi;
  logic [7:0]            len;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic [7:0]            beat_cnt;
  logic                  err;
  logic                  wlast_err;

  logic                  aw_hs, w_hs, b_hs, last_beat, wlast_bad;
  logic [ADDR_WIDTH-1:0] aw_bytes, aw_container, aw_lower;
  logic                  aw_err;
  logic [ADDR_WIDTH-1:0] bytes, incr_addr, next_addr;

  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign b_hs      = BVALID && BREADY;
  assign last_beat = (beat_cnt == len);
  assign wlast_bad = (WLAST != last_beat);
  assign dbg_state = state;

  // Wrap window is computed once at AW time so the per-beat path is a compare.
  assign aw_bytes     = ADDR_WIDTH'(1) << AWSIZE;
  assign aw_container = (ADDR_WIDTH'(AWLEN) + ADDR_WIDTH'(1)) << AWSIZE;
  assign aw_lower     = AWADDR & ~(aw_container - ADDR_WIDTH'(1));

  assign aw_err = (AWBURST == 2'b11) ||
                  (AWSIZE > 3'(MAX_SIZE)) ||
                  ((AWBURST == 2'b10) && !(AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
                  ((AWBURST == 2'b10) && ((AWADDR & (aw_bytes - ADDR_WIDTH'(1))) != '0));

  // Aligning before adding makes an unaligned first INCR beat land on the next boundary.
  assign bytes     = ADDR_WIDTH'(1) << size;
  assign incr_addr = (cur_addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;

  always_comb begin
    next_addr = incr_addr;
    case (burst)
      2'b00:   next_addr = cur_addr;
      2'b10:   next_addr = (incr_addr == wrap_hi) ? wrap_lo : incr_addr;
      default: next_addr = incr_addr;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (aw_hs) state_next = DATA;
      DATA:    if (w_hs && last_beat) state_next = RESP;
      RESP:    if (b_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= 2'b00;
      BID       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      cur_addr  <= '0;
      wrap_lo   <= '0;
      wrap_hi   <= '0;
      len       <= '0;
      size      <= '0;
      burst     <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
      wlast_err <= 1'b0;
    end else begin
      state   <= state_next;
      AWREADY <= (state_next == IDLE);
      WREADY  <= (state_next == DATA);
      BVALID  <= (state_next == RESP);
      mem_we  <= 1'b0;

      if (aw_hs) begin
        BID       <= AWID;
        cur_addr  <= AWADDR;
        wrap_lo   <= aw_lower;
        wrap_hi   <= aw_lower + aw_container;
        len       <= AWLEN;
        size      <= AWSIZE;
        burst     <= AWBURST;
        beat_cnt  <= '0;
        err       <= aw_err;
        wlast_err <= 1'b0;
      end

      if (w_hs) begin
        mem_we    <= !err;
        mem_addr  <= cur_addr;
        mem_wdata <= WDATA;
        mem_wstrb <= WSTRB;
        cur_addr  <= next_addr;
        beat_cnt  <= beat_cnt + 8'd1;
        wlast_err <= wlast_err || wlast_bad;
        if (last_beat) BRESP <= (err || wlast_err || wlast_bad) ? 2'b10 : 2'b00;
      end
    end
  end

endmodule

// File: doc/axi_slave_wr_ctrl.md
Name: axi_slave_wr_ctrl

Overview:
- AXI4 slave-side write-channel controller that sequences one write burst at a time: accepts AW, then W beats, then returns B.
- Generates per-beat byte addresses for FIXED, INCR and WRAP bursts and drives a simple synchronous memory write port with byte strobes.
- Sits between the VIP-facing AXI write channels and the DUT's local memory/register array; the read channels are out of scope.

Parameters:
ADDR_WIDTH, 32, width of AWADDR and mem_addr
DATA_WIDTH, 32, width of WDATA and mem_wdata; legal values 32/64/128
ID_WIDTH, 8, width of AWID and BID

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
AWID  in  ID_WIDTH  write transaction ID
AWADDR  in  ADDR_WIDTH  start byte address
AWLEN  in  8  beats minus one
AWSIZE  in  3  log2 bytes per beat
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWVALID  in  1  address valid
AWREADY  out  1  address accept
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte strobes
WLAST  in  1  last beat marker
WVALID  in  1  data valid
WREADY  out  1  data accept
BID  out  ID_WIDTH  response ID (= latched AWID)
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  response valid
BREADY  in  1  response accept
mem_we  out  1  one-cycle memory write enable
mem_addr  out  ADDR_WIDTH  byte address of the beat
mem_wdata  out  DATA_WIDTH  registered WDATA
mem_wstrb  out  DATA_WIDTH/8  registered WSTRB

Behaviour:
- Reset values: all outputs 0 (AWREADY=0, WREADY=0, BVALID=0, BRESP=00, BID=0, mem_we=0). State goes to IDLE. AWREADY rises in the first cycle after reset deasserts.
- FSM states: IDLE, DATA, RESP. AWREADY=1 only in IDLE; WREADY=1 only in DATA; BVALID=1 only in RESP. All three are registered from the next-state value.
- IDLE: on AWVALID&&AWREADY, latch ID/ADDR/LEN/SIZE/BURST, clear beat counter and error flag, then go to DATA. W is never accepted in IDLE, even if valid in the same cycle as AW.
- DATA, each W handshake:
  - The next cycle drives mem_we=1, mem_addr = current beat address, mem_wdata = WDATA, mem_wstrb = WSTRB. Write latency is one cycle from the handshake.
  - The beat counter increments. After beat AWLEN+1 is accepted, go to RESP; WREADY drops in that same next cycle.
- Beat address, with bytes = 1<<AWSIZE:
  - Beat 0 = AWADDR, unaligned allowed.
  - FIXED: every beat = AWADDR.
  - INCR: beat n = (AWADDR aligned down to bytes) + n*bytes, modulo 2^ADDR_WIDTH, no 4KB check.
  - WRAP: container = bytes*(AWLEN+1); lower = AWADDR aligned down to container; address increments by bytes and wraps to lower when it reaches lower+container.
- Error conditions set SLVERR and suppress mem_we for the whole burst; all beats are still accepted:
  - AWBURST=11;
  - AWSIZE > log2(DATA_WIDTH/8);
  - WRAP with AWLEN not in {1,3,7,15};
  - WRAP with AWADDR not aligned to bytes.
- WLAST mismatch (WLAST=1 before the final beat, or WLAST=0 on the final beat): BRESP=SLVERR. Memory writes are still performed and the beat count still governs completion.
- RESP: hold BVALID, BID, BRESP stable until BREADY. On the handshake go to IDLE, so AWREADY=1 the next cycle. Minimum turnaround is one RESP cycle; at most one outstanding transaction.
- Reset asserted mid-burst: abort immediately at that edge; no further mem_we and no B response for the aborted burst.

Test Plan:
- INCR, AWADDR=0x100, AWLEN=3, AWSIZE=2, all strobes -> mem_we pulses at 0x100/0x104/0x108/0x10C with matching data; BRESP=00, BID=AWID.
- WRAP, AWADDR=0x38, AWLEN=3, AWSIZE=2 -> addresses 0x38, 0x3C, 0x30, 0x34; BRESP=00.
- FIXED, AWADDR=0x20, AWLEN=2, WSTRB=0x1/0x2/0xF -> three writes to 0x20 with those strobes.
- AWBURST=11, AWLEN=1 -> two W beats accepted, mem_we never asserted, BRESP=10.
- INCR AWLEN=3 with WLAST on beat 2 -> four writes still occur; BRESP=10.
- BREADY held low for 5 cycles -> BVALID/BID/BRESP stable; AWREADY=0 until the cycle after BREADY. Reset after beat 1 of AWLEN=7 -> no further mem_we, no BVALID, AWREADY=1 the cycle after reset drops.
